vector_reduce_sum: RTL and testbench

- Serial reduction stage directly downstream of the element-wise vector multiplier.
- Captures one ARR vector of fixed-point products and sums its first `len` elements, one element per clock, using a wide two's-complement accumulator.
- Emits one saturated scalar in the same fixed-point format as the ARR elements.
- Together with the multiplier, this forms the dot product used for each neuron's weighted sum.

---
 rtl/vector_reduce_sum_pkg.sv | 30 +++
 rtl/vector_reduce_sum_sat_narrow.sv | 26 ++
 rtl/vector_reduce_sum.sv | 107 ++++++++++
 tb/tb_vector_reduce_sum.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_reduce_sum_pkg.sv
// Shared fixed-point vector types, limits and FSM states for the neuron datapath.
`timescale 1ns/1ps
package vector_reduce_sum_pkg;

    localparam int unsigned MAX_NEURONS = 8;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned FRAC_BITS   = 16;
    localparam int unsigned LEN_W       = $clog2(MAX_NEURONS) + 1;
    localparam int unsigned IDX_W       = $clog2(MAX_NEURONS);

    typedef logic [MAX_NEURONS-1:0][DATA_WIDTH-1:0] arr_t;

    localparam logic [DATA_WIDTH-1:0] FX_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] FX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Requested lengths beyond the vector size mean "the whole vector".
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l > LEN_W'(MAX_NEURONS)) begin
            return LEN_W'(MAX_NEURONS);
        end
        return l;
    endfunction

endpackage

// File: rtl/vector_reduce_sum_sat_narrow.sv
// Combinational two's-complement narrowing with saturation and overflow flag.
`timescale 1ns/1ps
module sat_narrow #(
    parameter int unsigned IN_W  = 40,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] sum_c,
    output logic             ovf_c
);

    localparam int unsigned HI_W = IN_W - OUT_W + 1;

    logic [HI_W-1:0] hi_bits;
    assign hi_bits = din[IN_W-1:OUT_W-1];

    // Value fits iff every bit from the result sign upward matches.
    always_comb begin
        ovf_c = !((&hi_bits) || (~|hi_bits));
        sum_c = din[OUT_W-1:0];
        if (ovf_c) begin
            sum_c = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/vector_reduce_sum.sv
// Serial saturating reduction of a product vector: one element per clock into a guarded accumulator.
`timescale 1ns/1ps
module vector_reduce_sum
    import vector_reduce_sum_pkg::*;
#(
    parameter int unsigned GUARD = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  arr_t                  in_vec,
    input  logic [LEN_W-1:0]      in_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned ACC_W = DATA_WIDTH + GUARD;

    state_t                  state;
    arr_t                    vbuf;
    logic [LEN_W-1:0]        len;
    logic [IDX_W-1:0]        idx;
    logic [ACC_W-1:0]        acc;

    logic [DATA_WIDTH-1:0]   elem;
    logic [ACC_W-1:0]        next_acc;
    logic [DATA_WIDTH-1:0]   sat_sum_c;
    logic                    sat_ovf_c;
    logic                    last_c;
    logic [LEN_W-1:0]        in_len_clamped;

    assign in_len_clamped = clamp_len(in_len);
    assign elem           = vbuf[idx];
    assign next_acc       = acc + {{GUARD{elem[DATA_WIDTH-1]}}, elem};
    assign last_c         = (LEN_W'(idx) == (len - LEN_W'(1)));

    // Saturate the post-add value so the final element lands in the registered result.
    sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH)
    ) u_sat (
        .din   (next_acc),
        .sum_c (sat_sum_c),
        .ovf_c (sat_ovf_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vbuf      <= '0;
            len       <= '0;
            idx       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vbuf     <= in_vec;
                        len      <= in_len_clamped;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        if (in_len_clamped == '0) begin
                            state     <= DONE;
                            out_sum   <= '0;
                            out_ovf   <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    acc <= next_acc;
                    idx <= idx + IDX_W'(1);
                    if (last_c) begin
                        state     <= DONE;
                        out_sum   <= sat_sum_c;
                        out_ovf   <= sat_ovf_c;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Result holds until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_reduce_sum.sv
// Self-checking bench for vector_reduce_sum against an arithmetic reference model.
`timescale 1ns/1ps
module tb_vector_reduce_sum;
    import vector_reduce_sum_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    arr_t                  in_vec;
    logic [LEN_W-1:0]      in_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_sum;
    logic                  out_ovf;
    logic                  out_valid;
    logic                  out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vector_reduce_sum dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference: exact integer sum of the first min(len, MAX) elements, then clamp.
    function automatic void ref_model(input arr_t v, input int l,
                                      output logic [31:0] s, output logic o);
        longint acc;
        int n;
        acc = 0;
        n = (l > int'(MAX_NEURONS)) ? int'(MAX_NEURONS) : l;
        for (int i = 0; i < n; i++) acc += longint'($signed(v[i]));
        if (acc > 64'sd2147483647) begin
            s = 32'h7FFF_FFFF; o = 1'b1;
        end else if (acc < -64'sd2147483648) begin
            s = 32'h8000_0000; o = 1'b1;
        end else begin
            s = acc[31:0]; o = 1'b0;
        end
    endfunction

    function automatic int ref_latency(input int l);
        int n;
        n = (l > int'(MAX_NEURONS)) ? int'(MAX_NEURONS) : l;
        return (n == 0) ? 1 : n + 1;
    endfunction

    function automatic arr_t random_vec();
        arr_t v;
        for (int i = 0; i < int'(MAX_NEURONS); i++) v[i] = $urandom;
        return v;
    endfunction

    // Present a vector (expects in_ready=1), then count cycles until out_valid.
    task automatic send(input arr_t v, input int l, output int lat);
        in_vec   = v;
        in_len   = LEN_W'(l);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = random_vec();
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_len = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'd0 || out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_sum=%h out_ovf=%b, want 1 0 0 0",
                     in_ready, out_valid, out_sum, out_ovf);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Directed vector with fixed expected result and latency.
    task automatic test_directed(input string name, input arr_t v, input int l,
                                 input logic [31:0] exp_sum, input logic exp_ovf, input int exp_lat);
        int lat;
        send(v, l, lat);
        checks++;
        if (out_sum !== exp_sum || out_ovf !== exp_ovf) begin
            failures++;
            $display("FAIL %s: out_sum=%h out_ovf=%b, want %h %b", name, out_sum, out_ovf, exp_sum, exp_ovf);
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, exp_lat);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_basic_sum();
        arr_t v;
        v = random_vec();
        v[0] = 32'h0001_0000; v[1] = 32'h0002_0000; v[2] = 32'h0000_8000; v[3] = 32'hFFFE_8000;
        test_directed("basic_sum", v, 4, 32'h0002_0000, 1'b0, 5);
    endtask

    task automatic test_len_edges();
        arr_t v;
        test_directed("len_zero", random_vec(), 0, 32'd0, 1'b0, 1);
        for (int i = 0; i < int'(MAX_NEURONS); i++) v[i] = 32'd1;
        test_directed("len_clamp", v, int'(MAX_NEURONS) + 3, 32'(MAX_NEURONS), 1'b0, int'(MAX_NEURONS) + 1);
    endtask

    task automatic test_saturation();
        arr_t v;
        v = random_vec();
        v[0] = 32'h7FFF_0000; v[1] = 32'h7FFF_0000; v[2] = 32'h7FFF_0000;
        test_directed("pos_sat", v, 3, 32'h7FFF_FFFF, 1'b1, 4);
        v = random_vec();
        v[0] = 32'h8000_0000; v[1] = 32'h8000_0000;
        test_directed("neg_sat", v, 2, 32'h8000_0000, 1'b1, 3);
        v = random_vec();
        v[0] = 32'h7FFF_0000; v[1] = 32'h7FFF_0000; v[2] = 32'h8001_0000;
        test_directed("recover", v, 3, 32'h7FFF_0000, 1'b0, 4);
    endtask

    task automatic test_random();
        arr_t v;
        int l, lat, wait_cycles;
        logic [31:0] es;
        logic eo;
        logic [31:0] held;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < int'(MAX_NEURONS); i++)
                v[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
            l = $urandom_range(0, int'(MAX_NEURONS) + 4);
            out_ready = 1'b0;
            ref_model(v, l, es, eo);
            send(v, l, lat);
            checks++;
            if (out_sum !== es || out_ovf !== eo || lat !== ref_latency(l)) begin
                failures++;
                $display("FAIL random[%0d] len=%0d: out_sum=%h out_ovf=%b lat=%0d, want %h %b %0d",
                         t, l, out_sum, out_ovf, lat, es, eo, ref_latency(l));
            end
            held = out_sum;
            wait_cycles = $urandom_range(0, 3);
            repeat (wait_cycles) @(posedge clk);
            #1;
            checks++;
            if (out_sum !== held || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL random_hold[%0d]: out_sum=%h out_valid=%b, want %h 1", t, out_sum, out_valid, held);
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        arr_t v;
        int lat;
        logic [31:0] es;
        logic eo;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            v = random_vec();
            ref_model(v, t + 1, es, eo);
            send(v, t + 1, lat);
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b1 || lat !== t + 2) begin
                failures++;
                $display("FAIL back_to_back[%0d]: in_ready=%b lat=%0d, want 1 %0d", t, in_ready, lat, t + 2);
            end
            checks++;
            if (es !== es) failures++;
        end
    endtask

    task automatic test_backpressure();
        arr_t v1, v2;
        int lat;
        int bad;
        logic [31:0] es1, es2, held;
        logic eo1, eo2;
        v1 = random_vec();
        v2 = random_vec();
        ref_model(v1, 5, es1, eo1);
        ref_model(v2, 6, es2, eo2);
        out_ready = 1'b0;
        send(v1, 5, lat);
        held = out_sum;
        in_vec = v2; in_len = LEN_W'(6); in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_sum !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || held !== es1) begin
            failures++;
            $display("FAIL backpressure: %0d unstable cycles, out_sum=%h want %h", bad, held, es1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        send(v2, 6, lat);
        checks++;
        if (out_sum !== es2 || out_ovf !== eo2 || lat !== 7) begin
            failures++;
            $display("FAIL bp_second: out_sum=%h out_ovf=%b lat=%0d, want %h %b 7", out_sum, out_ovf, lat, es2, eo2);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        arr_t v1, v2;
        int lat;
        logic [31:0] es;
        logic eo;
        v1 = random_vec();
        v2 = random_vec();
        for (int i = 0; i < int'(MAX_NEURONS); i++) v1[i] = 32'h7000_0000;
        in_vec = v1; in_len = LEN_W'(MAX_NEURONS); in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ref_model(v2, 4, es, eo);
        send(v2, 4, lat);
        checks++;
        if (out_sum !== es || out_ovf !== eo || lat !== 5) begin
            failures++;
            $display("FAIL reset_next: out_sum=%h out_ovf=%b lat=%0d, want %h %b 5", out_sum, out_ovf, lat, es, eo);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_len_edges();
        test_saturation();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
